// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared constants and types for the two-cache main-memory arbiter.
//   - MEM_ADDR_BITS / MEM_DATA_BITS : line-address and data widths of the
//     memory port shared by the instruction and data caches.
//   - OWN_DC / OWN_IC               : encodings of the owner register.
//   - arb_state_t                   : arbiter FSM states.
//   - cnt_width()                   : counter width helper that never
//     returns zero, so degenerate parameter values still elaborate.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int MEM_ADDR_BITS = 28;
    localparam int MEM_DATA_BITS = 128;

    localparam logic OWN_DC = 1'b0;
    localparam logic OWN_IC = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE      = 1'b0,
        ARB_READ_WAIT = 1'b1
    } arb_state_t;

    // Bits needed to hold values 0..n-1, at least one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   One memory request/response channel as used by both caches and by the
//   main-memory port.
//   Request  : req_valid/req_ready, req_addr, req_rw (1 = write)
//   Write    : req_data_valid/req_data_ready, req_data_bits, req_data_mask
//   Response : resp_valid, resp_data (BEATS beats per read, no backpressure)
//   Modports:
//     master - the side issuing requests (a cache, or the arbiter towards
//              memory)
//     slave  - the side accepting requests (the arbiter towards a cache, or
//              the memory model)
// ---------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_BITS,
    parameter int DATA_W = MEM_DATA_BITS
);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_rw;
    logic                  req_data_valid;
    logic                  req_data_ready;
    logic [DATA_W-1:0]     req_data_bits;
    logic [DATA_W/8-1:0]   req_data_mask;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_data;

    modport master (
        output req_valid,
        input  req_ready,
        output req_addr,
        output req_rw,
        output req_data_valid,
        input  req_data_ready,
        output req_data_bits,
        output req_data_mask,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_addr,
        input  req_rw,
        input  req_data_valid,
        output req_data_ready,
        input  req_data_bits,
        input  req_data_mask,
        output resp_valid,
        output resp_data
    );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single main-memory port between the instruction cache (ic)
//   and the data cache (dc). An explicit owner register decides which cache
//   is routed to memory; only the owner ever sees ready. Ownership toggles
//   after HOLD consecutive owner-idle cycles in IDLE, and only one read is
//   outstanding at a time (READ_WAIT collects BEATS response beats).
//
//   Ports
//     clk    : clock
//     reset  : synchronous, active-high reset (owner -> DC, state -> IDLE)
//     ic     : instruction-cache channel (arbiter is the slave)
//     dc     : data-cache channel (arbiter is the slave)
//     mem    : main-memory channel (arbiter is the master)
//
//   Parameters
//     ADDR_W : line-address width
//     DATA_W : data width
//     BEATS  : response beats per read request
//     HOLD   : owner-idle cycles before ownership toggles; must be >= 2 so a
//              new owner that samples ready and raises valid one cycle later
//              is never stranded
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_BITS,
    parameter int DATA_W = MEM_DATA_BITS,
    parameter int BEATS  = 4,
    parameter int HOLD   = 2
)(
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.slave    ic,
    mem_arbiter_if.slave    dc,
    mem_arbiter_if.master   mem
);

    localparam int IDLE_W = cnt_width(HOLD + 1);
    localparam int BEAT_W = cnt_width(BEATS);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HOLD - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t          state_q,    state_d;
    logic                owner_q,    owner_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;

    // Owner-selected request fields, produced by the owner mux below.
    logic                owner_valid;
    logic                owner_rw;
    logic                grant;
    logic                fire;

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_DC;
            idle_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            idle_cnt_q <= idle_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state, ownership rotation and beat counting
    // ------------------------------------------------------------------
    assign fire = mem.req_valid && mem.req_ready;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        beat_cnt_d = beat_cnt_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (fire) begin
                    // A completed request restarts the idle window, which
                    // is what keeps a busy owner from losing the port and
                    // gives the other cache its turn once the owner pauses.
                    idle_cnt_d = '0;
                    if (!owner_rw) begin
                        state_d    = ARB_READ_WAIT;
                        beat_cnt_d = '0;
                    end
                end else if (!owner_valid) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        owner_d    = ~owner_q;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    // Owner is waiting on memory backpressure: keep it.
                    idle_cnt_d = '0;
                end
            end

            ARB_READ_WAIT: begin
                if (mem.resp_valid) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d    = ARB_IDLE;
                        beat_cnt_d = '0;
                        idle_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: owner mux and output routing
    // ------------------------------------------------------------------
    always_comb begin
        // The request path is open only in IDLE and never during reset,
        // so a reset mid-transaction cannot leak a handshake.
        grant = (state_q == ARB_IDLE) && !reset;

        if (owner_q == OWN_IC) begin
            owner_valid           = ic.req_valid;
            owner_rw              = ic.req_rw;
            mem.req_addr          = ic.req_addr;
            mem.req_rw            = ic.req_rw;
            mem.req_data_valid    = ic.req_data_valid && grant;
            mem.req_data_bits     = ic.req_data_bits;
            mem.req_data_mask     = ic.req_data_mask;
        end else begin
            owner_valid           = dc.req_valid;
            owner_rw              = dc.req_rw;
            mem.req_addr          = dc.req_addr;
            mem.req_rw            = dc.req_rw;
            mem.req_data_valid    = dc.req_data_valid && grant;
            mem.req_data_bits     = dc.req_data_bits;
            mem.req_data_mask     = dc.req_data_mask;
        end

        mem.req_valid = owner_valid && grant;

        // Ready is shown only to the owner; caches sample it one cycle
        // before raising valid, so this is what steers them.
        ic.req_ready      = (owner_q == OWN_IC) && grant && mem.req_ready;
        ic.req_data_ready = (owner_q == OWN_IC) && grant && mem.req_data_ready;
        dc.req_ready      = (owner_q == OWN_DC) && grant && mem.req_ready;
        dc.req_data_ready = (owner_q == OWN_DC) && grant && mem.req_data_ready;

        // Response data is broadcast; only valid is steered. Beats outside
        // READ_WAIT (including strays after a reset) are dropped.
        ic.resp_data  = mem.resp_data;
        dc.resp_data  = mem.resp_data;
        ic.resp_valid = mem.resp_valid && (state_q == ARB_READ_WAIT) && !reset
                        && (owner_q == OWN_IC);
        dc.resp_valid = mem.resp_valid && (state_q == ARB_READ_WAIT) && !reset
                        && (owner_q == OWN_DC);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter (HOLD=2, BEATS=4). Inputs change at the
//   falling edge; outputs are compared 1 ns later, before the rising edge
//   commits the cycle.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ic_bus();
    mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) dc_bus();
    mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) mem_bus();

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .BEATS(4), .HOLD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .ic    (ic_bus),
        .dc    (dc_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ic_bus.req_valid = 0; ic_bus.req_addr = '0; ic_bus.req_rw = 0;
        ic_bus.req_data_valid = 0; ic_bus.req_data_bits = '0; ic_bus.req_data_mask = '0;
        dc_bus.req_valid = 0; dc_bus.req_addr = '0; dc_bus.req_rw = 0;
        dc_bus.req_data_valid = 0; dc_bus.req_data_bits = '0; dc_bus.req_data_mask = '0;
        mem_bus.req_ready = 1; mem_bus.req_data_ready = 1;
        mem_bus.resp_valid = 0; mem_bus.resp_data = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        dc_bus.req_valid = 1;
        ic_bus.req_valid = 1;
        @(negedge clk); #1;
        checks++; if (dc_bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_dc_ready: got %b expected 0", dc_bus.req_ready); end
        checks++; if (ic_bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ic_ready: got %b expected 0", ic_bus.req_ready); end
        checks++; if (mem_bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_bus.req_valid); end
        @(negedge clk);
        reset = 0;
        clear_inputs();
        $display("txn reset released");
    endtask

    task automatic test_dc_read();
        logic [127:0] exp_data;
        dc_bus.req_valid = 1; dc_bus.req_rw = 0; dc_bus.req_addr = 28'h0000010;
        #1;
        checks++; if (mem_bus.req_valid !== 1'b1) begin errors++; $display("FAIL dcrd_mem_valid: got %b expected 1", mem_bus.req_valid); end
        checks++; if (mem_bus.req_addr !== 28'h0000010) begin errors++; $display("FAIL dcrd_mem_addr: got %h expected 0000010", mem_bus.req_addr); end
        checks++; if (mem_bus.req_rw !== 1'b0) begin errors++; $display("FAIL dcrd_mem_rw: got %b expected 0", mem_bus.req_rw); end
        checks++; if (dc_bus.req_ready !== 1'b1) begin errors++; $display("FAIL dcrd_dc_ready: got %b expected 1", dc_bus.req_ready); end
        checks++; if (ic_bus.req_ready !== 1'b0) begin errors++; $display("FAIL dcrd_ic_ready: got %b expected 0", ic_bus.req_ready); end
        @(negedge clk);
        $display("txn dc read addr=0000010 issued");
        dc_bus.req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            exp_data = 128'hA + 128'(i);
            mem_bus.resp_valid = 1; mem_bus.resp_data = exp_data;
            #1;
            checks++; if (dc_bus.resp_valid !== 1'b1) begin errors++; $display("FAIL dcrd_resp_valid beat %0d: got %b expected 1", i, dc_bus.resp_valid); end
            checks++; if (dc_bus.resp_data !== exp_data) begin errors++; $display("FAIL dcrd_resp_data beat %0d: got %h expected %h", i, dc_bus.resp_data, exp_data); end
            checks++; if (ic_bus.resp_valid !== 1'b0) begin errors++; $display("FAIL dcrd_ic_resp beat %0d: got %b expected 0", i, ic_bus.resp_valid); end
            checks++; if (dc_bus.req_ready !== 1'b0) begin errors++; $display("FAIL dcrd_ready_in_wait beat %0d: got %b expected 0", i, dc_bus.req_ready); end
            @(negedge clk);
            $display("txn dc beat %0d data=%h", i, exp_data);
        end
        mem_bus.resp_valid = 0;
    endtask

    task automatic test_ic_takeover();
        logic [127:0] exp_data;
        ic_bus.req_valid = 1; ic_bus.req_rw = 0; ic_bus.req_addr = 28'h0000400;
        #1;
        checks++; if (dc_bus.req_ready !== 1'b1) begin errors++; $display("FAIL take_back_idle: got %b expected 1", dc_bus.req_ready); end
        checks++; if (ic_bus.req_ready !== 1'b0) begin errors++; $display("FAIL take_ic_ready_c0: got %b expected 0", ic_bus.req_ready); end
        @(negedge clk); #1;
        checks++; if (ic_bus.req_ready !== 1'b0) begin errors++; $display("FAIL take_ic_ready_c1: got %b expected 0", ic_bus.req_ready); end
        @(negedge clk); #1;
        checks++; if (ic_bus.req_ready !== 1'b1) begin errors++; $display("FAIL take_ic_ready_c2: got %b expected 1", ic_bus.req_ready); end
        checks++; if (mem_bus.req_addr !== 28'h0000400) begin errors++; $display("FAIL take_mem_addr: got %h expected 0000400", mem_bus.req_addr); end
        checks++; if (dc_bus.req_ready !== 1'b0) begin errors++; $display("FAIL take_dc_ready: got %b expected 0", dc_bus.req_ready); end
        @(negedge clk);
        $display("txn ic read addr=0000400 issued");
        ic_bus.req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            exp_data = 128'h100 + 128'(i);
            mem_bus.resp_valid = 1; mem_bus.resp_data = exp_data;
            #1;
            checks++; if (ic_bus.resp_valid !== 1'b1) begin errors++; $display("FAIL take_ic_resp beat %0d: got %b expected 1", i, ic_bus.resp_valid); end
            checks++; if (ic_bus.resp_data !== exp_data) begin errors++; $display("FAIL take_ic_data beat %0d: got %h expected %h", i, ic_bus.resp_data, exp_data); end
            checks++; if (dc_bus.resp_valid !== 1'b0) begin errors++; $display("FAIL take_dc_resp beat %0d: got %b expected 0", i, dc_bus.resp_valid); end
            @(negedge clk);
            $display("txn ic beat %0d data=%h", i, exp_data);
        end
        mem_bus.resp_valid = 0;
    endtask

    task automatic test_ic_write();
        logic [127:0] wdata;
        wdata = {4{32'hDEADBEEF}};
        ic_bus.req_valid = 1; ic_bus.req_rw = 1; ic_bus.req_addr = 28'h0000020;
        ic_bus.req_data_valid = 1; ic_bus.req_data_bits = wdata; ic_bus.req_data_mask = 16'hFFFF;
        #1;
        checks++; if (mem_bus.req_valid !== 1'b1) begin errors++; $display("FAIL wr_mem_valid: got %b expected 1", mem_bus.req_valid); end
        checks++; if (mem_bus.req_rw !== 1'b1) begin errors++; $display("FAIL wr_mem_rw: got %b expected 1", mem_bus.req_rw); end
        checks++; if (mem_bus.req_data_valid !== 1'b1) begin errors++; $display("FAIL wr_data_valid: got %b expected 1", mem_bus.req_data_valid); end
        checks++; if (mem_bus.req_data_bits !== wdata) begin errors++; $display("FAIL wr_data_bits: got %h expected %h", mem_bus.req_data_bits, wdata); end
        checks++; if (mem_bus.req_data_mask !== 16'hFFFF) begin errors++; $display("FAIL wr_data_mask: got %h expected ffff", mem_bus.req_data_mask); end
        checks++; if (ic_bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_ic_ready: got %b expected 1", ic_bus.req_ready); end
        checks++; if (ic_bus.req_data_ready !== 1'b1) begin errors++; $display("FAIL wr_ic_data_ready: got %b expected 1", ic_bus.req_data_ready); end
        checks++; if (dc_bus.req_data_ready !== 1'b0) begin errors++; $display("FAIL wr_dc_data_ready: got %b expected 0", dc_bus.req_data_ready); end
        @(negedge clk);
        $display("txn ic write addr=0000020 data=%h", wdata);
        ic_bus.req_valid = 0; ic_bus.req_data_valid = 0; ic_bus.req_rw = 0;
        #1;
        checks++; if (ic_bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_still_idle_ic: got %b expected 1", ic_bus.req_ready); end
        checks++; if (dc_bus.req_ready !== 1'b0) begin errors++; $display("FAIL wr_owner_kept: got %b expected 0", dc_bus.req_ready); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [127:0] exp_data;
        // Second idle cycle of the IC owner: ownership returns to DC.
        #1;
        checks++; if (dc_bus.req_ready !== 1'b0) begin errors++; $display("FAIL cont_pre_dc_ready: got %b expected 0", dc_bus.req_ready); end
        @(negedge clk);
        dc_bus.req_valid = 1; dc_bus.req_rw = 0; dc_bus.req_addr = 28'h0000030;
        ic_bus.req_valid = 1; ic_bus.req_rw = 0; ic_bus.req_addr = 28'h0000500;
        #1;
        checks++; if (mem_bus.req_addr !== 28'h0000030) begin errors++; $display("FAIL cont_mem_addr_dc: got %h expected 0000030", mem_bus.req_addr); end
        checks++; if (dc_bus.req_ready !== 1'b1) begin errors++; $display("FAIL cont_dc_ready: got %b expected 1", dc_bus.req_ready); end
        checks++; if (ic_bus.req_ready !== 1'b0) begin errors++; $display("FAIL cont_ic_ready: got %b expected 0", ic_bus.req_ready); end
        @(negedge clk);
        $display("txn dc read addr=0000030 issued, ic waiting");
        dc_bus.req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            exp_data = 128'h200 + 128'(i);
            mem_bus.resp_valid = 1; mem_bus.resp_data = exp_data;
            #1;
            checks++; if (dc_bus.resp_valid !== 1'b1) begin errors++; $display("FAIL cont_dc_resp beat %0d: got %b expected 1", i, dc_bus.resp_valid); end
            checks++; if (ic_bus.resp_valid !== 1'b0) begin errors++; $display("FAIL cont_ic_resp beat %0d: got %b expected 0", i, ic_bus.resp_valid); end
            checks++; if (mem_bus.req_valid !== 1'b0) begin errors++; $display("FAIL cont_mem_valid_wait beat %0d: got %b expected 0", i, mem_bus.req_valid); end
            @(negedge clk);
        end
        mem_bus.resp_valid = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (mem_bus.req_valid !== 1'b0) begin errors++; $display("FAIL cont_idle_mem_valid c%0d: got %b expected 0", c, mem_bus.req_valid); end
            checks++; if (ic_bus.req_ready !== 1'b0) begin errors++; $display("FAIL cont_idle_ic_ready c%0d: got %b expected 0", c, ic_bus.req_ready); end
            @(negedge clk);
        end
        #1;
        checks++; if (mem_bus.req_valid !== 1'b1) begin errors++; $display("FAIL cont_ic_mem_valid: got %b expected 1", mem_bus.req_valid); end
        checks++; if (mem_bus.req_addr !== 28'h0000500) begin errors++; $display("FAIL cont_ic_mem_addr: got %h expected 0000500", mem_bus.req_addr); end
        checks++; if (ic_bus.req_ready !== 1'b1) begin errors++; $display("FAIL cont_ic_ready_late: got %b expected 1", ic_bus.req_ready); end
        @(negedge clk);
        $display("txn ic read addr=0000500 issued");
        ic_bus.req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            mem_bus.resp_valid = 1; mem_bus.resp_data = 128'h300 + 128'(i);
            #1;
            checks++; if (ic_bus.resp_valid !== 1'b1) begin errors++; $display("FAIL cont_ic_beat %0d: got %b expected 1", i, ic_bus.resp_valid); end
            @(negedge clk);
        end
        mem_bus.resp_valid = 0;
    endtask

    task automatic test_backpressure();
        // IC owns after its read; two idle cycles hand ownership to DC.
        @(negedge clk);
        @(negedge clk);
        mem_bus.req_ready = 0;
        dc_bus.req_valid = 1; dc_bus.req_rw = 0; dc_bus.req_addr = 28'h0000060;
        ic_bus.req_valid = 1; ic_bus.req_rw = 0; ic_bus.req_addr = 28'h0000700;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (mem_bus.req_addr !== 28'h0000060) begin errors++; $display("FAIL bp_addr c%0d: got %h expected 0000060", c, mem_bus.req_addr); end
            checks++; if (dc_bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_dc_ready c%0d: got %b expected 0", c, dc_bus.req_ready); end
            @(negedge clk);
        end
        mem_bus.req_ready = 1;
        #1;
        checks++; if (dc_bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", dc_bus.req_ready); end
        checks++; if (mem_bus.req_addr !== 28'h0000060) begin errors++; $display("FAIL bp_release_addr: got %h expected 0000060", mem_bus.req_addr); end
        @(negedge clk);
        $display("txn dc read addr=0000060 issued after backpressure");
        dc_bus.req_valid = 0; ic_bus.req_valid = 0;
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < 2; i++) begin
            mem_bus.resp_valid = 1; mem_bus.resp_data = 128'h400 + 128'(i);
            #1;
            checks++; if (dc_bus.resp_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_beat %0d: got %b expected 1", i, dc_bus.resp_valid); end
            @(negedge clk);
        end
        reset = 1;
        dc_bus.req_valid = 1; ic_bus.req_valid = 1;
        mem_bus.resp_data = 128'h402;
        #1;
        checks++; if (dc_bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_resp: got %b expected 0", dc_bus.resp_valid); end
        checks++; if (dc_bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_dc_ready: got %b expected 0", dc_bus.req_ready); end
        checks++; if (ic_bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ic_ready: got %b expected 0", ic_bus.req_ready); end
        checks++; if (mem_bus.req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_valid: got %b expected 0", mem_bus.req_valid); end
        @(negedge clk);
        reset = 0;
        dc_bus.req_valid = 0;
        ic_bus.req_valid = 1; ic_bus.req_addr = 28'h0000800;
        mem_bus.resp_data = 128'h403;
        #1;
        checks++; if (dc_bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_post_dc_resp: got %b expected 0", dc_bus.resp_valid); end
        checks++; if (ic_bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_post_ic_resp: got %b expected 0", ic_bus.resp_valid); end
        checks++; if (dc_bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_post_dc_owner: got %b expected 1", dc_bus.req_ready); end
        checks++; if (ic_bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_post_ic_ready: got %b expected 0", ic_bus.req_ready); end
        @(negedge clk);
        $display("txn reset during read, stray beats dropped");
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1;
        clear_inputs();
        test_reset();
        test_dc_read();
        test_ic_takeover();
        test_ic_write();
        test_contention();
        test_backpressure();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
